seq_detector_param: RTL and testbench

- Parametrised Moore serial-pattern detector. It is the generalised successor to the team's fixed 4-bit sequence-detector FSM.
- Monitors a 1-bit serial input `w`, sampled on cycles where `en` is high.
- Raises `z` while the FSM sits in the terminal "pattern matched" state.
- Pattern length, pattern value and overlap mode are parameters. Includes a saturating match counter for the status logic.

---
 rtl/seq_detector_param_if.sv | 35 +++
 rtl/seq_detector_param.sv | 129 ++++++++++++
 tb/tb_seq_detector_param.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - serial pattern detector signal bundle
//
// Groups the detector's sample/clear inputs and its status outputs.
//   en          : sample enable, w is consumed only when high
//   w           : serial data bit
//   clr         : synchronous clear of match_count/count_sat
//   z           : Moore match flag
//   state_o     : matched-prefix length, for debug
//   match_count : saturating match counter
//   count_sat   : sticky counter-saturated flag
// master drives the inputs (stimulus side), slave is the detector.
interface seq_detector_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int SW = $clog2(N + 1);

  logic             en;
  logic             w;
  logic             clr;
  logic             z;
  logic [SW-1:0]    state_o;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output en, w, clr,
    input  z, state_o, match_count, count_sat
  );

  modport slave (
    input  en, w, clr,
    output z, state_o, match_count, count_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Moore serial pattern detector
//
// Tracks how many leading pattern bits the recent enabled samples of w
// match; state N is the match state and drives z. Transitions follow the
// KMP failure function, resolved into constants at elaboration.
// Ports:
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : seq_detector_param_if.slave (en, w, clr in; z, state_o,
//            match_count, count_sat out)
module seq_detector_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  seq_detector_param_if.slave  bus
);

  localparam int SW = $clog2(N + 1);
  typedef logic [SW-1:0] state_t;

  localparam state_t           S_MATCH   = state_t'(N);
  localparam logic [16:0]      PAT17     = 17'(PATTERN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_MAX - 1'b1;

  if (N < 1 || N > 16) begin : g_bad_n
    $error("seq_detector_param: N must be in 1..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be in 1..32");
  end

  function automatic logic bit_at(input logic [16:0] v, input int idx);
    return v[idx[4:0]];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, b).
  // Pattern bit i in arrival order is PATTERN[N-1-i].
  function automatic int kmp_next(input int k, input logic b);
    logic [16:0] hist;
    int          len;
    int          res;
    logic        ok;
    hist = '0;
    for (int i = 0; i < k; i++) begin
      hist = hist | (17'(bit_at(PAT17, N - 1 - i)) << i);
    end
    hist = hist | (17'(b) << k);
    len  = k + 1;
    res  = 0;
    for (int j = 1; j <= N; j++) begin
      if (j <= len) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          if (bit_at(hist, len - j + i) != bit_at(PAT17, N - 1 - i)) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          res = j;
        end
      end
    end
    return res;
  endfunction

  // Constant next-state tables indexed by current state; non-overlap
  // mode makes the match state behave like an empty history.
  state_t nxt0 [N+1];
  state_t nxt1 [N+1];

  for (genvar k = 0; k <= N; k++) begin : g_tab
    localparam int K_SRC = (k == N && !OVERLAP) ? 0 : k;
    assign nxt0[k] = state_t'(kmp_next(K_SRC, 1'b0));
    assign nxt1[k] = state_t'(kmp_next(K_SRC, 1'b1));
  end

  state_t           state;
  state_t           state_nxt;
  logic             match_hit;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= '0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    match_hit = 1'b0;
    if (int'(state) > N) begin
      // Unreachable encodings recover regardless of en.
      state_nxt = '0;
    end else if (bus.en) begin
      state_nxt = bus.w ? nxt1[state] : nxt0[state];
      match_hit = (state_nxt == S_MATCH);
    end
  end

  // clr wins over the old count but a coincident match still counts.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (bus.clr) begin
      cnt <= match_hit ? CNT_W'(1) : '0;
      sat <= 1'b0;
    end else if (match_hit && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_PENULT) begin
        sat <= 1'b1;
      end
    end
  end

  assign bus.z           = (state == S_MATCH);
  assign bus.state_o     = state;
  assign bus.match_count = cnt;
  assign bus.count_sat   = sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed bench for seq_detector_param
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param_if #(.N(4), .CNT_W(8)) ifa ();
  seq_detector_param_if #(.N(4), .CNT_W(8)) ifb ();
  seq_detector_param_if #(.N(1), .CNT_W(2)) ifc ();

  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .Clock(clk), .Resetn(rst_n), .bus(ifa)
  );
  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .Clock(clk), .Resetn(rst_n), .bus(ifb)
  );
  seq_detector_param #(.N(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .Clock(clk), .Resetn(rst_n), .bus(ifc)
  );

  logic st1 [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int   ta1 [7] = '{1, 2, 3, 4, 2, 3, 4};
  int   tb1 [7] = '{1, 2, 3, 4, 1, 0, 1};
  logic st2 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int   ta2 [5] = '{1, 2, 2, 3, 4};
  int   cnt_c [4] = '{1, 2, 3, 3};
  int   sat_c [4] = '{0, 0, 1, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    ifa.en  = 1'b0; ifa.w = 1'b0; ifa.clr = 1'b0;
    ifb.en  = 1'b0; ifb.w = 1'b0; ifb.clr = 1'b0;
    ifc.en  = 1'b0; ifc.w = 1'b0; ifc.clr = 1'b0;

    // reset and idle
    repeat (3) tick();
    chk("rst_state", 32'(ifa.state_o), 0);
    chk("rst_z", 32'(ifa.z), 0);
    chk("rst_count", 32'(ifa.match_count), 0);
    chk("rst_sat", 32'(ifa.count_sat), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifa.w = i[0];
      tick();
      chk("idle_state", 32'(ifa.state_o), 0);
      chk("idle_z", 32'(ifa.z), 0);
      chk("idle_count", 32'(ifa.match_count), 0);
    end

    // overlap (A) and non-overlap (B) on the same stream
    for (int i = 0; i < 7; i++) begin
      ifa.en = 1'b1; ifa.w = st1[i];
      ifb.en = 1'b1; ifb.w = st1[i];
      tick();
      chk("ovl_state", 32'(ifa.state_o), 32'(ta1[i]));
      chk("ovl_z", 32'(ifa.z), (ta1[i] == 4) ? 1 : 0);
      chk("novl_state", 32'(ifb.state_o), 32'(tb1[i]));
      chk("novl_z", 32'(ifb.z), (tb1[i] == 4) ? 1 : 0);
    end
    chk("ovl_count", 32'(ifa.match_count), 2);
    chk("novl_count", 32'(ifb.match_count), 1);
    ifa.en = 1'b0;
    ifb.en = 1'b0;

    // failure-function transition
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      ifa.en = 1'b1; ifa.w = st2[i];
      tick();
      chk("fail_state", 32'(ifa.state_o), 32'(ta2[i]));
      chk("fail_z", 32'(ifa.z), (ta2[i] == 4) ? 1 : 0);
    end
    ifa.en = 1'b0;

    // en gating
    pulse_reset();
    ifa.en = 1'b1; ifa.w = 1'b1; tick();
    chk("gate_b1", 32'(ifa.state_o), 1);
    ifa.w = 1'b1; tick();
    chk("gate_b2", 32'(ifa.state_o), 2);
    ifa.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifa.w = i[0];
      tick();
      chk("gate_hold", 32'(ifa.state_o), 2);
      chk("gate_hold_z", 32'(ifa.z), 0);
    end
    ifa.en = 1'b1; ifa.w = 1'b0; tick();
    chk("gate_b3", 32'(ifa.state_o), 3);
    ifa.w = 1'b1; tick();
    chk("gate_b4", 32'(ifa.state_o), 4);
    chk("gate_z", 32'(ifa.z), 1);
    ifa.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifa.w = ~i[0];
      tick();
      chk("gate_zhold", 32'(ifa.z), 1);
      chk("gate_cnt", 32'(ifa.match_count), 1);
    end

    // counter saturation, N=1, CNT_W=2
    for (int i = 0; i < 4; i++) begin
      ifc.en = 1'b1; ifc.w = 1'b1;
      tick();
      chk("c_z", 32'(ifc.z), 1);
      chk("c_count", 32'(ifc.match_count), 32'(cnt_c[i]));
      chk("c_sat", 32'(ifc.count_sat), 32'(sat_c[i]));
    end
    ifc.clr = 1'b1; tick();
    ifc.clr = 1'b0;
    chk("clr_count", 32'(ifc.match_count), 1);
    chk("clr_sat", 32'(ifc.count_sat), 0);
    chk("clr_z", 32'(ifc.z), 1);
    ifc.w = 1'b0; tick();
    chk("c_miss_z", 32'(ifc.z), 0);
    chk("c_miss_cnt", 32'(ifc.match_count), 1);
    ifc.w = 1'b1; tick();
    chk("c_cnt2", 32'(ifc.match_count), 2);

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("arst_c_state", 32'(ifc.state_o), 0);
    chk("arst_c_z", 32'(ifc.z), 0);
    chk("arst_c_cnt", 32'(ifc.match_count), 0);
    chk("arst_c_sat", 32'(ifc.count_sat), 0);
    chk("arst_a_state", 32'(ifa.state_o), 0);
    chk("arst_a_z", 32'(ifa.z), 0);
    ifc.en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
